expr_stack_unit: RTL and testbench
==================================

EXPR_STACK_UNIT -- requirements
Module: expr_stack_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning entry width in bits (min 1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning max entries (min 2); CW = clog2(DEPTH+1).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning a synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port op_valid, input, 1, meaning an operation is presented.
REQ-006 The block SHALL have port op_ready, output, 1, meaning the block can accept an operation.
REQ-007 The block SHALL have port op, input, 3, meaning operation: 000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 SWAP, 110 CLEAR, 111 NOP.
REQ-008 The block SHALL have port pop_amt, input, 1, meaning entries removed by POP/REPLACE: 0 = one, 1 = two.
REQ-009 The block SHALL have port din, input, WIDTH, meaning the value pushed by PUSH/REPLACE.
REQ-010 The block SHALL have port tos, output, WIDTH, meaning top entry; 0 when count < 1.
REQ-011 The block SHALL have port nos, output, WIDTH, meaning second entry; 0 when count < 2.
REQ-012 The block SHALL have port count, output, CW, meaning current number of entries.
REQ-013 The block SHALL have port overflow, output, 1, meaning a rejected op would have exceeded DEPTH.
REQ-014 The block SHALL have port underflow, output, 1, meaning a rejected op needed more entries than present.
REQ-015 The block SHALL have port err_clr, input, 1, meaning clear the fault condition.

Function
REQ-016 An op SHALL be accepted on a rising edge with op_valid=1 and op_ready=1; tos, nos and count SHALL reflect it from the next cycle (one-cycle latency, registered outputs).
REQ-017 PUSH SHALL require count<DEPTH and write din as new top, count+1.
REQ-018 POP SHALL require count>=N (N = pop_amt+1) and remove N entries.
REQ-019 REPLACE SHALL require count>=N, remove N entries, then push din, net count-N+1, in one cycle.
REQ-020 DUP SHALL require 1<=count<DEPTH and push a copy of tos.
REQ-021 SWAP SHALL require count>=2 and exchange tos and nos, count unchanged.
REQ-022 CLEAR SHALL set count to 0 in one cycle; the storage array need not be zeroed.
REQ-023 An op failing its requirement SHALL leave stack and count unchanged and set overflow (PUSH at full, DUP at full) or underflow (all other failures, including DUP at empty).
REQ-024 When an op fails, exactly one of overflow and underflow SHALL assert.
REQ-025 The FSM SHALL have states RUN and FAULT: RUN->FAULT on a failed op; FAULT->RUN on the edge where err_clr=1, with overflow/underflow cleared on that same edge.
REQ-026 In RUN op_ready SHALL be 1; in FAULT op_ready SHALL be 0 and stack contents SHALL be preserved.
REQ-027 err_clr in RUN SHALL have no effect.
REQ-028 op_valid with op_ready=0 SHALL be ignored.

Reset
REQ-029 reset=0 at a rising edge SHALL force state RUN, count=0, tos=0, nos=0, overflow=0, underflow=0 and op_ready=1, overriding any concurrent op or err_clr, including mid-fault.

Configuration
REQ-030 With macro ESU_STICKY_FAULT_EN defined, the FAULT state and err_clr SHALL behave per REQ-025..027.
REQ-031 Without ESU_STICKY_FAULT_EN, there SHALL be no FAULT state: op_ready SHALL be constant 1, err_clr SHALL be ignored, and overflow/underflow SHALL be one-cycle pulses in the cycle after the failed op.

Verification
REQ-032 The bench SHALL check reset, then PUSH 0x1111 and PUSH 0x2222 -> count=2, tos=0x2222, nos=0x1111.
REQ-033 The bench SHALL check, from that state, REPLACE pop_amt=1 din=0x3333 -> count=1, tos=0x3333, nos=0.
REQ-034 The bench SHALL check DEPTH=16: 16 PUSHes then a 17th PUSH -> count=16, overflow=1; sticky build: op_ready=0 until err_clr, then op_ready=1 with the stack intact.
REQ-035 The bench SHALL check POP pop_amt=1 with count=1 -> underflow=1, count=1, tos unchanged.
REQ-036 The bench SHALL check SWAP on (0xA, 0xB), then DUP -> tos=0xA, nos=0xA, count=3.
REQ-037 The bench SHALL check reset=0 asserted while in FAULT -> the next cycle shows count=0, flags=0, op_ready=1.

Source files
------------

// File: rtl/expr_stack_unit.sv
// Expression stack with PUSH/POP/REPLACE/DUP/SWAP/CLEAR and registered tos/nos/count.
// Define ESU_STICKY_FAULT_EN for a FAULT state that holds the flags until err_clr.
module expr_stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic             pop_amt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPLACE = 3'b011;
    localparam logic [2:0] OP_DUP     = 3'b100;
    localparam logic [2:0] OP_SWAP    = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic [CW-1:0]    n_cw;
    logic [WIDTH-1:0] m2, m3, m4;
    logic [CW-1:0]    count_n;
    logic [WIDTH-1:0] tos_n, nos_n;
    logic             ovf_n, unf_n;
    logic             wr0_en, wr1_en;
    logic [IW-1:0]    wr0_idx, wr1_idx;
    logic [WIDTH-1:0] wr0_data, wr1_data;

    assign accept = op_valid && op_ready;
    assign n_cw   = pop_amt ? CW'(2) : CW'(1);

    // Entries 2..4 below the current top; these become tos/nos after a POP or REPLACE.
    always_comb begin
        m2 = (count >= CW'(2)) ? mem[IW'(count - CW'(2))] : '0;
        m3 = (count >= CW'(3)) ? mem[IW'(count - CW'(3))] : '0;
        m4 = (count >= CW'(4)) ? mem[IW'(count - CW'(4))] : '0;
    end

    // mem[count-1] always mirrors tos and mem[count-2] mirrors nos.
    always_comb begin
        count_n  = count;
        tos_n    = tos;
        nos_n    = nos;
        ovf_n    = 1'b0;
        unf_n    = 1'b0;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_idx  = '0;
        wr1_idx  = '0;
        wr0_data = '0;
        wr1_data = '0;
        if (accept) begin
            case (op)
                OP_PUSH: begin
                    if (count < DEPTH_C) begin
                        wr0_en   = 1'b1;
                        wr0_idx  = IW'(count);
                        wr0_data = din;
                        count_n  = count + CW'(1);
                        tos_n    = din;
                        nos_n    = tos;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                OP_POP: begin
                    if (count >= n_cw) begin
                        count_n = count - n_cw;
                        tos_n   = pop_amt ? m3 : m2;
                        nos_n   = pop_amt ? m4 : m3;
                    end else begin
                        unf_n = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (count >= n_cw) begin
                        wr0_en   = 1'b1;
                        wr0_idx  = IW'(count - n_cw);
                        wr0_data = din;
                        count_n  = count - n_cw + CW'(1);
                        tos_n    = din;
                        nos_n    = pop_amt ? m3 : m2;
                    end else begin
                        unf_n = 1'b1;
                    end
                end
                OP_DUP: begin
                    if (count == '0) begin
                        unf_n = 1'b1;
                    end else if (count >= DEPTH_C) begin
                        ovf_n = 1'b1;
                    end else begin
                        wr0_en   = 1'b1;
                        wr0_idx  = IW'(count);
                        wr0_data = tos;
                        count_n  = count + CW'(1);
                        nos_n    = tos;
                    end
                end
                OP_SWAP: begin
                    if (count >= CW'(2)) begin
                        wr0_en   = 1'b1;
                        wr0_idx  = IW'(count - CW'(1));
                        wr0_data = nos;
                        wr1_en   = 1'b1;
                        wr1_idx  = IW'(count - CW'(2));
                        wr1_data = tos;
                        tos_n    = nos;
                        nos_n    = tos;
                    end else begin
                        unf_n = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    count_n = '0;
                    tos_n   = '0;
                    nos_n   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr0_en) mem[wr0_idx] <= wr0_data;
            if (wr1_en) mem[wr1_idx] <= wr1_data;
        end
    end

`ifdef ESU_STICKY_FAULT_EN
    typedef enum logic {RUN, FAULT} state_t;
    state_t state;

    // A failed op parks the block in FAULT with its flag held until err_clr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            op_ready  <= 1'b1;
            count     <= '0;
            tos       <= '0;
            nos       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_n;
            tos   <= tos_n;
            nos   <= nos_n;
            case (state)
                RUN: begin
                    if (ovf_n || unf_n) begin
                        state     <= FAULT;
                        op_ready  <= 1'b0;
                        overflow  <= ovf_n;
                        underflow <= unf_n;
                    end
                end
                FAULT: begin
                    if (err_clr) begin
                        state     <= RUN;
                        op_ready  <= 1'b1;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign op_ready       = 1'b1;

    // Without a fault state the flags are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            tos       <= '0;
            nos       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_n;
            tos       <= tos_n;
            nos       <= nos_n;
            overflow  <= ovf_n;
            underflow <= unf_n;
        end
    end
`endif

endmodule

// File: tb/tb_expr_stack_unit.sv
// Directed bench for expr_stack_unit; follows ESU_STICKY_FAULT_EN if defined.
module tb_expr_stack_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [2:0] NOP     = 3'b000;
    localparam logic [2:0] PUSH    = 3'b001;
    localparam logic [2:0] POP     = 3'b010;
    localparam logic [2:0] REPLACE = 3'b011;
    localparam logic [2:0] DUP     = 3'b100;
    localparam logic [2:0] SWAP    = 3'b101;
    localparam logic [2:0] CLEAR   = 3'b110;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic             pop_amt;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    int checks = 0;
    int passes = 0;

    expr_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .pop_amt(pop_amt), .din(din), .tos(tos), .nos(nos),
        .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Presents one op for exactly one rising edge; outputs are settled on return.
    task automatic applyStimulus(input logic [2:0] o, input logic amt, input logic [WIDTH-1:0] d);
        op_valid = 1'b1;
        op       = o;
        pop_amt  = amt;
        din      = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic checkStack(input string tag, input int c, input logic [WIDTH-1:0] t,
                              input logic [WIDTH-1:0] n);
        checkOutput({tag, ".count"}, 32'(count), 32'(c));
        checkOutput({tag, ".tos"}, 32'(tos), 32'(t));
        checkOutput({tag, ".nos"}, 32'(nos), 32'(n));
    endtask

    task automatic checkFlags(input string tag, input logic ov, input logic un);
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'(un));
    endtask

    // Leaves the fault condition and confirms the flags drop with the stack untouched.
    task automatic recoverFault(input string tag, input int c, input logic [WIDTH-1:0] t,
                                input logic [WIDTH-1:0] n);
`ifdef ESU_STICKY_FAULT_EN
        checkOutput({tag, ".ready_in_fault"}, 32'(op_ready), 32'd0);
        applyStimulus(PUSH, 1'b0, 16'hDEAD);
        checkStack({tag, ".ignored"}, c, t, n);
        checkOutput({tag, ".still_fault"}, 32'(op_ready), 32'd0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
`else
        applyStimulus(NOP, 1'b0, '0);
`endif
        checkOutput({tag, ".ready_after"}, 32'(op_ready), 32'd1);
        checkFlags({tag, ".cleared"}, 1'b0, 1'b0);
        checkStack({tag, ".intact"}, c, t, n);
    endtask

    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        op       = NOP;
        pop_amt  = 1'b0;
        din      = '0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        checkStack("reset", 0, 16'h0, 16'h0);
        checkFlags("reset", 1'b0, 1'b0);
        checkOutput("reset.ready", 32'(op_ready), 32'd1);

        applyStimulus(DUP, 1'b0, '0);
        checkFlags("dup_empty", 1'b0, 1'b1);
        checkStack("dup_empty", 0, 16'h0, 16'h0);
        recoverFault("dup_empty", 0, 16'h0, 16'h0);

        applyStimulus(PUSH, 1'b0, 16'h1111);
        checkStack("push1", 1, 16'h1111, 16'h0);
        applyStimulus(PUSH, 1'b0, 16'h2222);
        checkStack("push2", 2, 16'h2222, 16'h1111);

        applyStimulus(REPLACE, 1'b1, 16'h3333);
        checkStack("replace2", 1, 16'h3333, 16'h0);

        applyStimulus(POP, 1'b1, '0);
        checkFlags("pop2_short", 1'b0, 1'b1);
        checkStack("pop2_short", 1, 16'h3333, 16'h0);
        recoverFault("pop2_short", 1, 16'h3333, 16'h0);

        applyStimulus(CLEAR, 1'b0, '0);
        checkStack("clear", 0, 16'h0, 16'h0);

        applyStimulus(PUSH, 1'b0, 16'h000A);
        applyStimulus(PUSH, 1'b0, 16'h000B);
        applyStimulus(SWAP, 1'b0, '0);
        checkStack("swap", 2, 16'h000A, 16'h000B);
        applyStimulus(DUP, 1'b0, '0);
        checkStack("dup", 3, 16'h000A, 16'h000A);
        applyStimulus(REPLACE, 1'b0, 16'h000C);
        checkStack("replace1", 3, 16'h000C, 16'h000A);
        applyStimulus(POP, 1'b0, '0);
        checkStack("pop1", 2, 16'h000A, 16'h000B);
        applyStimulus(POP, 1'b1, '0);
        checkStack("pop2", 0, 16'h0, 16'h0);
        checkFlags("pop2", 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(PUSH, 1'b0, 16'h0100 + 16'(i));
        checkStack("fill", 16, 16'h010F, 16'h010E);
        checkFlags("fill", 1'b0, 1'b0);
        applyStimulus(PUSH, 1'b0, 16'h0BAD);
        checkFlags("push_full", 1'b1, 1'b0);
        checkStack("push_full", 16, 16'h010F, 16'h010E);
        recoverFault("push_full", 16, 16'h010F, 16'h010E);

        applyStimulus(DUP, 1'b0, '0);
        checkFlags("dup_full", 1'b1, 1'b0);
        checkStack("dup_full", 16, 16'h010F, 16'h010E);
        reset    = 1'b0;
        err_clr  = 1'b1;
        applyStimulus(PUSH, 1'b0, 16'h5555);
        reset    = 1'b1;
        err_clr  = 1'b0;
        checkStack("reset_fault", 0, 16'h0, 16'h0);
        checkFlags("reset_fault", 1'b0, 1'b0);
        checkOutput("reset_fault.ready", 32'(op_ready), 32'd1);

        applyStimulus(PUSH, 1'b0, 16'h7777);
        checkStack("post_reset", 1, 16'h7777, 16'h0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
